// File: rtl/rf_cfg_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_cfg_seq_pkg
//  Purpose  : Shared constants for the RF configuration sequencer: select-mode
//             codes, error codes, FSM state encoding and shadow file depth.
//  Revision : 1.0  initial release
// ============================================================================
package rf_cfg_seq_pkg;

  // Number of ADF4351 registers (R0..R5) held in the shadow file
  localparam int SHD_DEPTH = 6;

  // Downstream select-mode codes
  typedef enum logic [2:0] {
    MODE_ADF = 3'd0,
    MODE_ADS = 3'd1,
    MODE_OFF = 3'd2
  } mode_t;

  // Error codes reported on err_code (ERR_RSVD is never produced)
  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_SPI_TO = 2'd1,
    ERR_RD_TO  = 2'd2,
    ERR_RSVD   = 2'd3
  } err_code_t;

  // Sequencer FSM encoding
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_LOAD      = 4'd1;
  localparam logic [3:0] ST_SETL      = 4'd2;
  localparam logic [3:0] ST_START     = 4'd3;
  localparam logic [3:0] ST_WAIT      = 4'd4;
  localparam logic [3:0] ST_NEXT      = 4'd5;
  localparam logic [3:0] ST_MON_SETL  = 4'd6;
  localparam logic [3:0] ST_MON_START = 4'd7;
  localparam logic [3:0] ST_MON_RD    = 4'd8;

endpackage
`default_nettype wire

// File: rtl/rf_cfg_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : rf_cfg_seq_if
//  Purpose  : Bundles the shadow-write, control, SPI handshake and readback
//             signals of rf_cfg_seq. slave = sequencer, master = its driver.
//  Revision : 1.0  initial release
// ============================================================================
interface rf_cfg_seq_if;
  logic        shd_wr_en;
  logic [2:0]  shd_addr;
  logic [31:0] shd_data;
  logic        freq_cfg_start;
  logic        mon_en;
  logic        rf_spi_done;
  logic [31:0] rf_cfg_rd_data;
  logic        rf_cfg_rd_valid;
  logic [2:0]  rf_cfg_select_mode;
  logic [31:0] rf_cfg_wr_data;
  logic [7:0]  rf_cfg_addr;
  logic        rf_cfg_wr_en;
  logic        rf_cfg_valid;
  logic        adf4351_spi_start;
  logic        ads8332_spi_start;
  logic        seq_busy;
  logic        seq_done;
  logic        seq_err;
  logic [1:0]  err_code;
  logic [31:0] mon_data;
  logic        mon_valid;

  modport slave (
    input  shd_wr_en, shd_addr, shd_data, freq_cfg_start, mon_en,
           rf_spi_done, rf_cfg_rd_data, rf_cfg_rd_valid,
    output rf_cfg_select_mode, rf_cfg_wr_data, rf_cfg_addr, rf_cfg_wr_en,
           rf_cfg_valid, adf4351_spi_start, ads8332_spi_start, seq_busy,
           seq_done, seq_err, err_code, mon_data, mon_valid
  );

  modport master (
    output shd_wr_en, shd_addr, shd_data, freq_cfg_start, mon_en,
           rf_spi_done, rf_cfg_rd_data, rf_cfg_rd_valid,
    input  rf_cfg_select_mode, rf_cfg_wr_data, rf_cfg_addr, rf_cfg_wr_en,
           rf_cfg_valid, adf4351_spi_start, ads8332_spi_start, seq_busy,
           seq_done, seq_err, err_code, mon_data, mon_valid
  );
endinterface
`default_nettype wire

// File: rtl/rf_cfg_seq_shadow_regs.sv
`default_nettype none
// ============================================================================
//  Module   : rf_cfg_shadow_regs
//  Purpose  : 6x32 ADF4351 shadow register file, one write port, asynchronous
//             read. Writes to indices beyond the depth are dropped.
//  Revision : 1.0  initial release
// ============================================================================
module rf_cfg_shadow_regs
  import rf_cfg_seq_pkg::*;
(
  input  wire logic        i_clk,
  input  wire logic        i_rst,
  input  wire logic        i_wr_en,
  input  wire logic [2:0]  i_wr_addr,
  input  wire logic [31:0] i_wr_data,
  input  wire logic [2:0]  i_rd_idx,
  output logic      [31:0] o_rd_data
);

  logic [31:0] r_mem [SHD_DEPTH];

  // Single write port; the whole file clears on reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < SHD_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_wr_en && (i_wr_addr < 3'(SHD_DEPTH))) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = (i_rd_idx < 3'(SHD_DEPTH)) ? r_mem[i_rd_idx] : '0;

endmodule
`default_nettype wire

// File: rtl/rf_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module   : rf_cfg_seq
//  Purpose  : Programs ADF4351 registers R5..R0 from a shadow file over the
//             shared RF config path and periodically reads the ADS8332
//             monitor while idle. SETTLE must be at least 1.
//  Revision : 1.0  initial release
// ============================================================================
module rf_cfg_seq
  import rf_cfg_seq_pkg::*;
#(
  parameter int SPI_TIMEOUT = 4096,
  parameter int MON_PERIOD  = 100000,
  parameter int SETTLE      = 2
) (
  input  wire logic   spi_clk,
  input  wire logic   sys_rest,
  rf_cfg_seq_if.slave bus
);

  localparam int TMR_W = $clog2((SPI_TIMEOUT > SETTLE) ? SPI_TIMEOUT : SETTLE) + 1;
  localparam int MON_W = $clog2(MON_PERIOD) + 1;
  localparam logic [TMR_W-1:0] c_to_last     = TMR_W'(SPI_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] c_settle_last = TMR_W'(SETTLE - 1);
  localparam logic [MON_W-1:0] c_mon_last    = MON_W'(MON_PERIOD - 1);

  logic [3:0]       r_state;
  logic [2:0]       r_idx;
  logic [TMR_W-1:0] r_tmr;
  logic [MON_W-1:0] r_mon_cnt;
  logic             r_pend;
  logic             r_seq_err;
  logic [1:0]       r_err_code;
  logic [31:0]      r_mon_data;
  logic             r_mon_valid;
  logic [31:0]      w_shd;
  logic [2:0]       w_mode;
  logic             w_wr;
  logic             w_adf_start;
  logic             w_ads_start;

  rf_cfg_shadow_regs u_shadow (
    .i_clk     (spi_clk),
    .i_rst     (sys_rest),
    .i_wr_en   (bus.shd_wr_en),
    .i_wr_addr (bus.shd_addr),
    .i_wr_data (bus.shd_data),
    .i_rd_idx  (r_idx),
    .o_rd_data (w_shd)
  );

  // Sequencer FSM with settle/timeout timer, monitor period counter and pending start
  always_ff @(posedge spi_clk or posedge sys_rest) begin
    if (sys_rest) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_tmr       <= '0;
      r_mon_cnt   <= '0;
      r_pend      <= 1'b0;
      r_seq_err   <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_mon_data  <= '0;
      r_mon_valid <= 1'b0;
    end else begin
      r_mon_valid <= 1'b0;
      // A start outside IDLE is remembered once; extra ones fold into the same flag
      if ((r_state != ST_IDLE) && bus.freq_cfg_start) r_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_tmr <= '0;
          if (bus.freq_cfg_start || r_pend) begin
            r_pend     <= 1'b0;
            r_idx      <= 3'(SHD_DEPTH - 1);
            r_seq_err  <= 1'b0;
            r_err_code <= ERR_NONE;
            r_mon_cnt  <= '0;
            r_state    <= ST_LOAD;
          end else if (!bus.mon_en) begin
            r_mon_cnt <= '0;
          end else if (r_mon_cnt == c_mon_last) begin
            r_mon_cnt <= '0;
            r_state   <= ST_MON_SETL;
          end else begin
            r_mon_cnt <= r_mon_cnt + 1'b1;
          end
        end
        ST_LOAD: begin
          r_tmr   <= '0;
          r_state <= ST_SETL;
        end
        ST_SETL: begin
          if (r_tmr == c_settle_last) begin
            r_tmr   <= '0;
            r_state <= ST_START;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_START: begin
          r_tmr   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.rf_spi_done) begin
            r_state <= ST_NEXT;
          end else if (r_tmr == c_to_last) begin
            r_seq_err  <= 1'b1;
            r_err_code <= ERR_SPI_TO;
            r_state    <= ST_IDLE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_NEXT: begin
          if (r_idx == 3'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_idx   <= r_idx - 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_MON_SETL: begin
          if (r_tmr == c_settle_last) begin
            r_tmr   <= '0;
            r_state <= ST_MON_START;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_MON_START: begin
          r_tmr   <= '0;
          r_state <= ST_MON_RD;
        end
        ST_MON_RD: begin
          if (bus.rf_cfg_rd_valid) begin
            r_mon_data  <= bus.rf_cfg_rd_data;
            r_mon_valid <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (r_tmr == c_to_last) begin
            r_seq_err  <= 1'b1;
            r_err_code <= ERR_RD_TO;
            r_state    <= ST_IDLE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Moore decode of select mode, write strobe and SPI start pulses
  always_comb begin
    w_mode      = MODE_OFF;
    w_wr        = 1'b0;
    w_adf_start = 1'b0;
    w_ads_start = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_mode = MODE_ADF;
        w_wr   = 1'b1;
      end
      ST_SETL, ST_WAIT, ST_NEXT: w_mode = MODE_ADF;
      ST_START: begin
        w_mode      = MODE_ADF;
        w_adf_start = 1'b1;
      end
      ST_MON_SETL, ST_MON_RD: w_mode = MODE_ADS;
      ST_MON_START: begin
        w_mode      = MODE_ADS;
        w_ads_start = 1'b1;
      end
      default: w_mode = MODE_OFF;
    endcase
  end

  // The ADF4351 control bits [2:0] always carry the register index
  assign bus.rf_cfg_wr_data     = (w_shd & 32'hFFFF_FFF8) | {29'd0, r_idx};
  assign bus.rf_cfg_addr        = {5'd0, r_idx};
  assign bus.rf_cfg_select_mode = w_mode;
  assign bus.rf_cfg_wr_en       = w_wr;
  assign bus.rf_cfg_valid       = w_wr;
  assign bus.adf4351_spi_start  = w_adf_start;
  assign bus.ads8332_spi_start  = w_ads_start;
  assign bus.seq_busy           = (r_state != ST_IDLE);
  assign bus.seq_done           = (r_state == ST_NEXT) && (r_idx == 3'd0);
  assign bus.seq_err            = r_seq_err;
  assign bus.err_code           = r_err_code;
  assign bus.mon_data           = r_mon_data;
  assign bus.mon_valid          = r_mon_valid;

endmodule
`default_nettype wire

// File: doc/rf_cfg_seq.md
RF_CFG_SEQ -- requirements
Module: rf_cfg_seq

Interface
REQ-001 Parameter SPI_TIMEOUT, default 4096: max spi_clk cycles waited for any SPI completion.
REQ-002 Parameter MON_PERIOD, default 100000: spi_clk cycles between ADS8332 monitor reads.
REQ-003 Parameter SETTLE, default 2: cycles between a select-mode change and the following SPI start pulse.
REQ-004 spi_clk  in  1  sole clock; all logic rising-edge.
REQ-005 sys_rest  in  1  reset, asynchronous, active-high.
REQ-006 shd_wr_en  in  1  one-cycle write strobe into the ADF4351 shadow register file.
REQ-007 shd_addr  in  3  shadow index 0..5; values 6 and 7 ignored.
REQ-008 shd_data  in  32  shadow write data.
REQ-009 freq_cfg_start  in  1  one-cycle pulse: program R5..R0 into ADF4351.
REQ-010 mon_en  in  1  level: enables periodic ADS8332 reads while idle.
REQ-011 rf_spi_done  in  1  one-cycle pulse per completed SPI transaction.
REQ-012 rf_cfg_rd_data  in  32  / rf_cfg_rd_valid  in  1: readback from the RF config stage.
REQ-013 rf_cfg_select_mode  out  3  0 = ADF4351, 1 = ADS8332, 2 = off.
REQ-014 rf_cfg_wr_data  out  32 / rf_cfg_addr  out  8 / rf_cfg_wr_en  out  1 / rf_cfg_valid  out  1: word presented downstream.
REQ-015 adf4351_spi_start  out  1 / ads8332_spi_start  out  1: one-cycle SPI start pulses.
REQ-016 seq_busy  out  1; seq_done  out  1 (pulse); seq_err  out  1 (sticky); err_code  out  2.
REQ-017 mon_data  out  32 / mon_valid  out  1 (pulse): latest ADS8332 readback.

Function
REQ-018 Shadow writes are accepted every cycle, including while busy; a write takes effect from the next LOAD onward.
REQ-019 FSM states: IDLE, LOAD, SETL, START, WAIT, NEXT, MON_SETL, MON_START, MON_RD.
REQ-020 In IDLE, freq_cfg_start loads idx = 5, clears seq_err and err_code, and goes to LOAD.
REQ-021 LOAD (1 cycle): mode = 0; rf_cfg_wr_data = {shadow[idx][31:3], idx[2:0]}; rf_cfg_addr = {5'd0, idx}; rf_cfg_wr_en = rf_cfg_valid = 1 for that cycle only.
REQ-022 SETL: hold SETL cycles, then go to START.
REQ-023 START: adf4351_spi_start = 1 for exactly 1 cycle, then go to WAIT.
REQ-024 WAIT: rf_spi_done -> NEXT.
REQ-025 WAIT timeout: if SPI_TIMEOUT cycles elapse without done, set seq_err, set err_code = 1, force mode = 2, go to IDLE, and do not assert seq_done.
REQ-026 NEXT: if idx = 0, pulse seq_done and go to IDLE; otherwise decrement idx and go to LOAD. R0 is always written last.
REQ-027 Monitor counter runs only in IDLE with mon_en = 1; it resets to 0 on leaving IDLE or when mon_en = 0.
REQ-028 When the monitor counter reaches MON_PERIOD-1: go to MON_SETL with mode = 1.
REQ-029 MON_SETL waits SETTLE cycles, then MON_START pulses ads8332_spi_start for 1 cycle, then MON_RD.
REQ-030 MON_RD: rf_cfg_rd_valid latches rf_cfg_rd_data into mon_data, pulses mon_valid, and returns to IDLE.
REQ-031 MON_RD timeout: after SPI_TIMEOUT cycles, set seq_err, set err_code = 2, return to IDLE.
REQ-032 freq_cfg_start arriving in any non-IDLE state is captured in a pending flag (depth 1). It is served on the next entry to IDLE, with priority over the monitor. Further starts while pending are dropped.
REQ-033 If freq_cfg_start and the monitor terminal count coincide in IDLE, programming wins.
REQ-034 seq_busy = 1 in every state except IDLE.
REQ-035 In IDLE, mode = 2, and rf_cfg_wr_en / rf_cfg_valid = 0.
REQ-036 rf_spi_done outside WAIT is ignored. rf_cfg_rd_valid outside MON_RD is ignored.
REQ-037 err_code 3 is reserved; err_code holds its value until the next accepted freq_cfg_start.

Reset
REQ-038 While sys_rest is asserted: all outputs are 0 except rf_cfg_select_mode = 2; FSM = IDLE; idx = 0; counters and pending flag are cleared; shadow registers are cleared to 0.
REQ-039 A reset mid-sequence aborts immediately with no seq_done. Operation resumes on the first spi_clk edge after deassertion.

Structure
REQ-040 A shared package holds: mode constants (ADF = 0, ADS = 1, OFF = 2), err_code constants, FSM state encoding, and the 6-entry shadow depth.
REQ-041 One sub-module, rf_cfg_shadow_regs, implements the 6x32 shadow file with a single write port and an asynchronous read on idx.

Verification
REQ-042 Program shadow[i] = 32'hA5A5_A5A0+i, pulse start, return rf_spi_done 10 cycles after each start -> six LOADs, addr 5,4,3,2,1,0, data low bits = addr, seq_done after the 6th done.
REQ-043 Start with no rf_spi_done -> after 4096 WAIT cycles, seq_err = 1, err_code = 1, mode = 2, no seq_done.
REQ-044 Set mon_en = 1 with MON_PERIOD = 16, return rf_cfg_rd_valid with data 32'h0000_1234 -> ads8332_spi_start every cycle of the monitor loop, mon_data = 32'h1234, one mon_valid pulse per read.
REQ-045 Pulse freq_cfg_start during MON_RD -> the read completes, then programming starts on the cycle after IDLE entry.
REQ-046 Assert sys_rest during WAIT at idx = 3 -> outputs reset asynchronously, mode = 2; a new start after release begins at idx 5.
